// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and constants for the registered 1:4 demux.
//               The macro DEMUX_CNT_EN enables per-lane delivered-word counters.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int DEMUX_WIDTH = 48;
   localparam int DEMUX_LANES = 4;
   localparam int CNT_W       = 16;

   // Destination select encoding carried on in_sel
   typedef enum logic [1:0] {
      LANE0 = 2'b00,
      LANE1 = 2'b01,
      LANE2 = 2'b10,
      LANE3 = 2'b11
   } lane_sel_t;

   // One-hot decode of a lane select
   function automatic logic [DEMUX_LANES-1:0] sel_decode(input logic [1:0] sel);
      return DEMUX_LANES'(1) << sel;
   endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_lane.sv
`default_nettype none
// ============================================================================
// Module      : demux_lane
// Description : One output lane of the demux: a single-word holding register
//               with valid/ready handshake. A load in the same cycle as a
//               delivery replaces the word and keeps the lane valid.
//               With DEMUX_CNT_EN defined, a 16-bit wrapping counter tracks
//               delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_lane
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] o_cnt
`endif
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             w_deliver;

   assign w_deliver = r_valid & i_ready;

   // Holding register: load wins over deliver; the data is kept after delivery
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (w_deliver) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Delivered-word counter, wraps naturally at 16 bits
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_deliver) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
`endif

endmodule : demux_lane
`default_nettype wire

// File: rtl/demux1_4_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux1_4_reg
// Description : Registered 1-to-4 demultiplexer for the 48-bit P-side
//               datapath. Each lane has its own valid/ready handshake, so a
//               stalled lane never blocks words addressed to other lanes.
//               Optional feature macro: DEMUX_CNT_EN (per-lane counters).
// Revision    : 1.0 - initial release
// ============================================================================
module demux1_4_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
`endif
);

   logic                   w_accept;
   logic [DEMUX_LANES-1:0] w_load;
   logic [DEMUX_LANES-1:0] w_valid;
   logic [WIDTH-1:0]       w_data [DEMUX_LANES];
`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0]       w_cnt  [DEMUX_LANES];
`endif

   // Only the addressed lane decides whether the word can be taken; a lane
   // that is delivering this cycle frees its slot for a simultaneous load
   assign in_ready = !w_valid[in_sel] || out_ready[in_sel];
   assign w_accept = in_valid && in_ready;
   assign w_load   = w_accept ? sel_decode(in_sel) : '0;

   generate
      for (genvar n = 0; n < DEMUX_LANES; n++) begin : g_lane
         demux_lane #(
            .WIDTH   (WIDTH)
         ) u_lane (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_load  (w_load[n]),
            .i_data  (in_data),
            .i_ready (out_ready[n]),
            .o_data  (w_data[n]),
            .o_valid (w_valid[n])
`ifdef DEMUX_CNT_EN
            ,
            .o_cnt   (w_cnt[n])
`endif
         );
      end
   endgenerate

   assign out0      = w_data[0];
   assign out1      = w_data[1];
   assign out2      = w_data[2];
   assign out3      = w_data[3];
   assign out_valid = w_valid;

`ifdef DEMUX_CNT_EN
   assign cnt0 = w_cnt[0];
   assign cnt1 = w_cnt[1];
   assign cnt2 = w_cnt[2];
   assign cnt3 = w_cnt[3];
`endif

endmodule : demux1_4_reg
`default_nettype wire

// File: tb/tb_demux1_4_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_demux1_4_reg
// Description : Self-checking bench for demux1_4_reg. A per-lane queue holds
//               the words accepted for each lane; they are popped and compared
//               whenever a lane delivers. Build with DEMUX_CNT_EN to exercise
//               the delivered-word counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1_4_reg;

   logic        CLK;
   logic        RST;
   logic [47:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] out0, out1, out2, out3;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
`ifdef DEMUX_CNT_EN
   logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

   int          checks;
   int          errors;

   // Reference state: expected valid flags, last loaded word per lane,
   // and a queue of undelivered words per lane
   logic [3:0]  m_v;
   logic [47:0] m_last [4];
   logic [47:0] q [4][$];

   demux1_4_reg dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [47:0] lane_out(input int n);
      case (n)
         0:       return out0;
         1:       return out1;
         2:       return out2;
         default: return out3;
      endcase
   endfunction

   // Drive one cycle of stimulus from a negedge, score deliveries and the
   // load, then advance to the next negedge and check registered state
   task automatic step(input logic v, input logic [1:0] s, input logic [47:0] d,
                       input logic [3:0] rdy, output logic acc);
      logic        exp_rdy;
      logic [47:0] exp_w;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = rdy;
      #1;
      exp_rdy = !m_v[s] || rdy[s];
      checks++;
      if (in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL in_ready sel=%0d got %b want %b", s, in_ready, exp_rdy);
      end
      acc = v && exp_rdy;
      for (int n = 0; n < 4; n++) begin
         if (m_v[n] && rdy[n]) begin
            exp_w = (q[n].size() > 0) ? q[n].pop_front() : 48'hX;
            checks++;
            if (lane_out(n) !== exp_w) begin
               errors++;
               $display("FAIL deliver lane%0d got %h want %h", n, lane_out(n), exp_w);
            end
            m_v[n] = 1'b0;
         end
      end
      if (acc) begin
         q[s].push_back(d);
         m_v[s]    = 1'b1;
         m_last[s] = d;
      end
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (out_valid !== m_v) begin
         errors++;
         $display("FAIL out_valid got %b want %b", out_valid, m_v);
      end
      for (int n = 0; n < 4; n++) begin
         checks++;
         if (lane_out(n) !== m_last[n]) begin
            errors++;
            $display("FAIL out%0d hold got %h want %h", n, lane_out(n), m_last[n]);
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      RST       = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 48'hABCDEF012345;
      out_ready = 4'hF;
      repeat (cycles) @(posedge CLK);
      @(negedge CLK);
      RST      = 1'b0;
      in_valid = 1'b0;
      m_v      = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         m_last[n] = 48'h0;
         q[n].delete();
      end
   endtask

   task automatic drain();
      logic acc;
      step(1'b0, 2'd0, 48'h0, 4'hF, acc);
      step(1'b0, 2'd0, 48'h0, 4'hF, acc);
   endtask

   task automatic test_reset();
      do_reset(2);
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL reset_valid got %b want 0000", out_valid);
      end
      checks++;
      if ({out0, out1, out2, out3} !== 192'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h %h want 0", out0, out1, out2, out3);
      end
`ifdef DEMUX_CNT_EN
      checks++;
      if ({cnt0, cnt1, cnt2, cnt3} !== 64'h0) begin
         errors++;
         $display("FAIL reset_cnt got %h %h %h %h want 0", cnt0, cnt1, cnt2, cnt3);
      end
`endif
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      out_ready = 4'h0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_routing();
      logic [47:0] words [4];
      logic        acc;
      words[0] = 48'h000000000001;
      words[1] = 48'h0000000000A2;
      words[2] = 48'hFFFFFFFFFFFF;
      words[3] = 48'h123456789ABC;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 2'(i), words[i], 4'hF, acc);
         checks++;
         if (out_valid !== (4'b0001 << i) || lane_out(i) !== words[i]) begin
            errors++;
            $display("FAIL route%0d got valid %b data %h want valid %b data %h",
                     i, out_valid, lane_out(i), 4'b0001 << i, words[i]);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic acc;
      step(1'b1, 2'd2, 48'hDEAD, 4'b1011, acc);
      step(1'b1, 2'd2, 48'hBEEF, 4'b1011, acc);
      checks++;
      if (acc !== 1'b0 || out2 !== 48'hDEAD) begin
         errors++;
         $display("FAIL bp_stall got ready %b out2 %h want 0 DEAD", acc, out2);
      end
      step(1'b1, 2'd1, 48'h111111111111, 4'b1011, acc);
      checks++;
      if (acc !== 1'b1 || out1 !== 48'h111111111111) begin
         errors++;
         $display("FAIL bp_other got ready %b out1 %h want 1 111111111111", acc, out1);
      end
      step(1'b1, 2'd2, 48'hBEEF, 4'b1111, acc);
      checks++;
      if (acc !== 1'b1 || out2 !== 48'hBEEF || out_valid[2] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got ready %b out2 %h v %b want 1 BEEF 1",
                  acc, out2, out_valid[2]);
      end
      drain();
   endtask

   task automatic test_deliver_load();
      logic acc;
      step(1'b1, 2'd0, 48'h77, 4'b0000, acc);
      step(1'b1, 2'd0, 48'h55, 4'b0001, acc);
      checks++;
      if (acc !== 1'b1 || out_valid[0] !== 1'b1 || out0 !== 48'h55) begin
         errors++;
         $display("FAIL dl got ready %b v %b out0 %h want 1 1 55",
                  acc, out_valid[0], out0);
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      logic acc;
      step(1'b1, 2'd0, 48'hA0A0, 4'b0000, acc);
      step(1'b1, 2'd3, 48'hB3B3, 4'b0000, acc);
      do_reset(1);
      checks++;
      if (out_valid !== 4'b0000 || out0 !== 48'h0 || out3 !== 48'h0) begin
         errors++;
         $display("FAIL midreset got valid %b out0 %h out3 %h want 0000 0 0",
                  out_valid, out0, out3);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic acc;
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              {16'($urandom), 32'($urandom)}, 4'($urandom), acc);
      end
      drain();
   endtask

`ifdef DEMUX_CNT_EN
   task automatic test_counter();
      logic acc;
      do_reset(1);
      for (int i = 0; i < 65537; i++) begin
         step(1'b1, 2'd1, 48'(i), 4'b0010, acc);
      end
      drain();
      checks++;
      if (cnt1 !== 16'd1 || cnt0 !== 16'd0 || cnt2 !== 16'd0 || cnt3 !== 16'd0) begin
         errors++;
         $display("FAIL cnt_wrap got %h %h %h %h want 0 1 0 0", cnt0, cnt1, cnt2, cnt3);
      end
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      RST       = 1'b1;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = 48'h0;
      out_ready = 4'h0;
      m_v       = 4'b0000;
      @(negedge CLK);
      test_reset();
      test_routing();
      test_backpressure();
      test_deliver_load();
      test_reset_midstream();
      test_back_to_back();
`ifdef DEMUX_CNT_EN
      test_counter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_demux1_4_reg
`default_nettype wire
